card_shoe: RTL and testbench
============================

// Module: card_shoe
// PURPOSE
//  Single-deck card source that sits directly upstream of the blackjack game FSM and drives its card_value input.
//  Holds 52 ranks and shuffles them in place with an LFSR-driven Fisher-Yates pass.
//  Deals one card per draw request, with no replacement, until the deck is exhausted or reshuffled.
// PARAMETERS
//  SEED  16'hACE1  initial LFSR state; a value of 0 is replaced by 16'h0001
// PORTS
//  clk           input   1  system clock, rising edge
//  rst           input   1  asynchronous, active-high reset
//  shuffle_req   input   1  one-cycle pulse: restore all 52 cards and shuffle
//  draw_req      input   1  one-cycle pulse: deal the top card
//  card_value    output  4  blackjack value of the last dealt card (1=Ace, 2..10; J/Q/K=10)
//  card_rank     output  4  rank of the last dealt card (1..13), for display
//  card_valid    output  1  one-cycle pulse: card_value/card_rank updated this cycle
//  cards_left    output  6  undealt cards remaining, 0..52
//  empty         output  1  high when cards_left==0
//  busy          output  1  high while in SHUFFLE
// BEHAVIOUR
//  Clock and reset: one clock, asynchronous active-high reset.
//  Reset values:
//   - deck[k] = (k mod 13)+1 for k=0..51 (ordered deck); ptr=0
//   - cards_left=52, empty=0, busy=0, card_valid=0, card_value=0, card_rank=0
//   - LFSR=SEED; state=READY
//  LFSR:
//   - 16-bit Fibonacci, taps 16,14,13,11
//   - Steps every cycle in every state; it never holds, so player timing adds entropy
//  FSM states: READY, SHUFFLE.
//  READY:
//   - shuffle_req: i<=51, ptr<=0, cards_left<=52, go to SHUFFLE; busy=1 from the next cycle
//   - draw_req with cards_left>0, and no shuffle_req in the same cycle:
//     - next cycle: card_rank<=deck[ptr], card_value<=min(deck[ptr],10), card_valid=1
//     - ptr<=ptr+1, cards_left<=cards_left-1
//     - latency is exactly 1 cycle
//   - draw_req with cards_left==0: ignored; no card_valid, outputs hold
//   - shuffle_req and draw_req in the same cycle: shuffle wins; the draw is dropped
//  SHUFFLE (one candidate per cycle, rejection sampling):
//   - r = LFSR[5:0]
//   - if r<=i: swap deck[i] and deck[r], then i<=i-1
//   - else: retry next cycle with the new LFSR value
//   - i==0: go to READY, busy=0 in the following cycle
//   - all 52 ranks are preserved: only swaps occur
//   - draw_req and shuffle_req are ignored; card_valid stays 0
//  card_valid is a single-cycle pulse; card_value and card_rank hold until the next deal.
//  Reset mid-shuffle restores the ordered deck immediately and returns to READY.
//  cards_left never wraps: no decrement at 0, and it never exceeds 52.
//  The consumer must issue draw_req only when it is ready to latch card_value on the following cycle.
// TESTING
//  1. Reset, then 13 draws one per cycle -> card_value 1,2..9,10,10,10,10; card_rank 1..13; cards_left 39.
//  2. From reset, 52 draws -> empty=1 after the 52nd; a 53rd draw gives no card_valid and cards_left stays 0.
//  3. shuffle_req -> busy=1 next cycle, busy eventually drops, cards_left=52; 52 draws sum to 340, each rank exactly 4x.
//  4. shuffle_req and draw_req in the same cycle -> no card_valid; shuffle starts.
//  5. draw_req while busy -> ignored; cards_left unchanged after the shuffle completes.
//  6. rst asserted mid-shuffle -> busy=0, cards_left=52; the next draw gives card_rank=1.

Source files
------------

// File: rtl/card_shoe_if.sv
// Request/response bundle between the blackjack controller and the card shoe.
// The controller owns the request pulses; the shoe owns everything else.
interface card_shoe_if;
    logic       shuffle_req;
    logic       draw_req;
    logic [3:0] card_value;
    logic [3:0] card_rank;
    logic       card_valid;
    logic [5:0] cards_left;
    logic       empty;
    logic       busy;

    modport master (
        output shuffle_req, draw_req,
        input  card_value, card_rank, card_valid, cards_left, empty, busy
    );

    modport slave (
        input  shuffle_req, draw_req,
        output card_value, card_rank, card_valid, cards_left, empty, busy
    );
endinterface

// File: rtl/card_shoe.sv
// Single 52-card deck, shuffled in place by an LFSR-driven Fisher-Yates pass,
// dealt one card per draw_req without replacement.
module card_shoe #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic         clk,
    input  logic         rst,
    card_shoe_if.slave   shoe
);
    localparam logic [15:0] SEED_NZ = (SEED == 16'h0000) ? 16'h0001 : SEED;

    typedef enum logic {READY, SHUFFLE} state_t;

    state_t     state;
    logic [3:0] deck [52];
    logic [5:0] ptr;
    logic [5:0] idx;
    logic [5:0] cards_left;
    logic [15:0] lfsr;
    logic [5:0] r;
    logic       fb;
    logic [3:0] card_value, card_rank;
    logic       card_valid, busy;

    assign r  = lfsr[5:0];
    assign fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 52; k++) deck[k] <= 4'((k % 13) + 1);
            state      <= READY;
            ptr        <= '0;
            idx        <= '0;
            cards_left <= 6'd52;
            lfsr       <= SEED_NZ;
            card_value <= '0;
            card_rank  <= '0;
            card_valid <= 1'b0;
            busy       <= 1'b0;
        end else begin
            // Free-running so the consumer's request timing perturbs the shuffle.
            lfsr       <= {lfsr[14:0], fb};
            card_valid <= 1'b0;
            case (state)
                READY: begin
                    if (shoe.shuffle_req) begin
                        idx        <= 6'd51;
                        ptr        <= '0;
                        cards_left <= 6'd52;
                        busy       <= 1'b1;
                        state      <= SHUFFLE;
                    end else if (shoe.draw_req && cards_left != '0) begin
                        card_rank  <= deck[ptr];
                        card_value <= (deck[ptr] > 4'd10) ? 4'd10 : deck[ptr];
                        card_valid <= 1'b1;
                        ptr        <= ptr + 6'd1;
                        cards_left <= cards_left - 6'd1;
                    end
                end
                SHUFFLE: begin
                    if (idx == '0) begin
                        busy  <= 1'b0;
                        state <= READY;
                    end else if (r <= idx) begin
                        // Rejection sampling keeps r uniform over 0..idx.
                        deck[idx] <= deck[r];
                        deck[r]   <= deck[idx];
                        idx       <= idx - 6'd1;
                    end
                end
                default: state <= READY;
            endcase
        end
    end

    assign shoe.card_value = card_value;
    assign shoe.card_rank  = card_rank;
    assign shoe.card_valid = card_valid;
    assign shoe.cards_left = cards_left;
    assign shoe.empty      = (cards_left == '0);
    assign shoe.busy       = busy;
endmodule

// File: tb/tb_card_shoe.sv
// Scoreboard bench for card_shoe: a deck/LFSR reference model predicts every
// dealt card; a negedge monitor pops and compares whenever card_valid is seen.
module tb_card_shoe;
    localparam logic [15:0] SEED = 16'hACE1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    card_shoe_if bus ();

    card_shoe #(.SEED(SEED)) dut (.clk(clk), .rst(rst), .shoe(bus));

    typedef struct {
        int rank;
        int value;
        int due;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    // Reference model state
    logic [15:0] m_lfsr;
    int          m_arr [52];
    int          m_ptr;
    int          busy_cnt;

    int obs_cnt [14];
    int obs_sum;
    int last_r, last_v;

    function automatic logic [15:0] lfsr_next(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or posedge rst)
        if (rst) m_lfsr <= SEED;
        else     m_lfsr <= lfsr_next(m_lfsr);

    task automatic model_reset();
        for (int k = 0; k < 52; k++) m_arr[k] = (k % 13) + 1;
        m_ptr    = 0;
        busy_cnt = 0;
        exp_q.delete();
    endtask

    // Fisher-Yates with rejection sampling over the LFSR sequence that starts
    // with the value visible in the first busy cycle.
    task automatic model_shuffle(input logic [15:0] start);
        logic [15:0] l;
        int i, r, t, n;
        l = start; i = 51; n = 0;
        while (i > 0) begin
            r = int'(l[5:0]);
            if (r <= i) begin
                t = m_arr[i]; m_arr[i] = m_arr[r]; m_arr[r] = t;
                i--;
            end
            l = lfsr_next(l);
            n++;
            if (n > 20000) begin
                chk("shuffle_model_bound", n, 20000);
                break;
            end
        end
        m_ptr    = 0;
        busy_cnt = n + 1;
    endtask

    // One clock of stimulus; the model advances with the same edge.
    task automatic step(input bit s, input bit d);
        bus.shuffle_req = s;
        bus.draw_req    = d;
        @(posedge clk);
        #1;
        bus.shuffle_req = 1'b0;
        bus.draw_req    = 1'b0;
        if (busy_cnt > 0) busy_cnt--;
        else if (s) model_shuffle(m_lfsr);
        else if (d && m_ptr < 52) begin
            exp_q.push_back('{m_arr[m_ptr], (m_arr[m_ptr] > 10) ? 10 : m_arr[m_ptr], cyc});
            m_ptr++;
        end
        chk("busy", int'(bus.busy), int'(busy_cnt > 0));
        chk("cards_left", int'(bus.cards_left), 52 - m_ptr);
        chk("empty", int'(bus.empty), int'(m_ptr == 52));
    endtask

    task automatic wait_idle();
        while (busy_cnt > 0) step(1'b0, 1'b0);
    endtask

    task automatic clear_obs();
        for (int k = 0; k < 14; k++) obs_cnt[k] = 0;
        obs_sum = 0;
    endtask

    // Monitor: compares dealt cards and the hold behaviour between deals.
    always @(negedge clk) begin
        if (rst) begin
            last_r = 0;
            last_v = 0;
        end else if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("card_valid", int'(bus.card_valid), 1);
            chk("card_rank", int'(bus.card_rank), e.rank);
            chk("card_value", int'(bus.card_value), e.value);
            last_r = e.rank;
            last_v = e.value;
            if (bus.card_rank <= 4'd13) obs_cnt[bus.card_rank]++;
            obs_sum += int'(bus.card_value);
        end else begin
            chk("no_card_valid", int'(bus.card_valid), 0);
            chk("rank_hold", int'(bus.card_rank), last_r);
            chk("value_hold", int'(bus.card_value), last_v);
        end
    end

    initial begin
        bus.shuffle_req = 1'b0;
        bus.draw_req    = 1'b0;
        model_reset();
        clear_obs();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cards_left", int'(bus.cards_left), 52);
        chk("rst_empty", int'(bus.empty), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_valid", int'(bus.card_valid), 0);
        chk("rst_value", int'(bus.card_value), 0);
        chk("rst_rank", int'(bus.card_rank), 0);
        @(negedge clk); #2; rst = 1'b0;

        // Ordered deck: first 13 cards are ranks 1..13
        repeat (13) step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        chk("after13_cards_left", int'(bus.cards_left), 39);

        // Drain, then a draw on an empty deck
        repeat (39) step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        chk("drained_empty", int'(bus.empty), 1);
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        chk("draw53_cards_left", int'(bus.cards_left), 0);

        // Shuffle then deal the whole deck
        step(1'b1, 1'b0);
        chk("busy_after_shuffle", int'(bus.busy), 1);
        wait_idle();
        clear_obs();
        repeat (52) step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        chk("shuffled_sum", obs_sum, 340);
        for (int k = 1; k <= 13; k++) chk("rank_count", obs_cnt[k], 4);

        // Shuffle and draw together, then draws while busy
        step(1'b1, 1'b1);
        repeat (6) step(1'b0, 1'b1);
        wait_idle();
        chk("cards_left_post_busy", int'(bus.cards_left), 52);
        repeat (5) step(1'b0, 1'b1);

        // Randomised traffic
        for (int n = 0; n < 2000; n++)
            step($urandom_range(0, 99) < 3, $urandom_range(0, 99) < 60);
        wait_idle();

        // Reset in the middle of a shuffle
        step(1'b1, 1'b0);
        repeat (10) step(1'b0, 1'b0);
        rst = 1'b1;
        #2;
        model_reset();
        chk("midrst_busy", int'(bus.busy), 0);
        chk("midrst_cards_left", int'(bus.cards_left), 52);
        @(negedge clk); #2; rst = 1'b0;
        @(posedge clk); #1;
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        chk("midrst_rank_seen", last_r, 1);

        repeat (2) step(1'b0, 1'b0);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
